// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Opcode encodings and FSM state type shared by the integer
//             execute unit and its serial divider.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Base / alternate ALU operations (funct7 = 0x00 / 0x20)
  localparam logic [2:0] F3_ADD  = 3'd0;  // ADD, SUB with F7_ALT
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;  // SRL, SRA with F7_ALT
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  // Multiply / divide operations (funct7 = 0x01)
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : div_iter
//  Purpose  : Restoring radix-2 serial divider on unsigned magnitudes.
//             One quotient bit per cycle; o_done is high in the final step
//             cycle with the finished quotient/remainder on the outputs.
//  Revision : 1.0  initial release
// ============================================================================
module div_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_quotient,
  output logic [DATA_WIDTH-1:0] o_remainder
);

  localparam int c_CW = $clog2(DATA_WIDTH) + 1;

  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [DATA_WIDTH-1:0] r_dvs;
  logic [c_CW-1:0]       r_cnt;
  logic                  r_busy;

  logic [DATA_WIDTH:0]   w_trial;
  logic                  w_ge;
  logic [DATA_WIDTH-1:0] w_rem_nxt;
  logic [DATA_WIDTH-1:0] w_quo_nxt;

  // Partial remainder shifted left by one with the next dividend bit; a
  // clear top bit after subtraction means the divisor fits.
  assign w_trial   = {r_rem, r_quo[DATA_WIDTH-1]} - {1'b0, r_dvs};
  assign w_ge      = ~w_trial[DATA_WIDTH];
  assign w_rem_nxt = w_ge ? w_trial[DATA_WIDTH-1:0]
                          : {r_rem[DATA_WIDTH-2:0], r_quo[DATA_WIDTH-1]};
  assign w_quo_nxt = {r_quo[DATA_WIDTH-2:0], w_ge};

  // Results are taken from the next-state values so the caller can register
  // them on the same edge as the last step.
  assign o_done      = r_busy && (r_cnt == c_CW'(1));
  assign o_quotient  = w_quo_nxt;
  assign o_remainder = w_rem_nxt;

  // Load operands on start, then iterate DATA_WIDTH steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_dvs  <= i_divisor;
      r_cnt  <= c_CW'(DATA_WIDTH);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= w_rem_nxt;
      r_quo  <= w_quo_nxt;
      r_cnt  <= r_cnt - c_CW'(1);
      if (r_cnt == c_CW'(1)) r_busy <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : alu_muldiv
//  Purpose  : Execute-stage integer unit: RV32I ALU ops plus RV32M
//             multiply/divide with valid/ready on both sides. Divides that
//             are not special cases run on the serial divider.
//  Revision : 1.0  initial release
// ============================================================================
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5,
  parameter int MULDIV_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,        // asynchronous, active-low
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] lhs,
  input  logic [DATA_WIDTH-1:0] rhs,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]  tag_out,
  output logic                  illegal
);

  localparam int c_SHW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] c_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  alu_state_t              r_state;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_result;
  logic [TAG_WIDTH-1:0]    r_tag;
  logic                    r_illegal;
  logic                    r_neg_q;
  logic                    r_neg_r;
  logic                    r_is_rem;
  logic [TAG_WIDTH-1:0]    r_div_tag;

  logic                    w_accept;
  logic                    w_div_go;
  logic                    w_div_start;
  logic                    w_div_done;
  logic [DATA_WIDTH-1:0]   w_res;
  logic                    w_illegal;
  logic [c_SHW-1:0]        w_shamt;
  logic [2*DATA_WIDTH-1:0] w_a_ext;
  logic [2*DATA_WIDTH-1:0] w_b_ext;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic                    w_div_signed;
  logic                    w_div_rem;
  logic                    w_lhs_neg;
  logic                    w_rhs_neg;
  logic [DATA_WIDTH-1:0]   w_lhs_mag;
  logic [DATA_WIDTH-1:0]   w_rhs_mag;
  logic                    w_div_by0;
  logic                    w_div_ovf;
  logic [DATA_WIDTH-1:0]   w_q;
  logic [DATA_WIDTH-1:0]   w_r;
  logic [DATA_WIDTH-1:0]   w_div_res;

  assign in_ready    = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_div_start = w_accept && w_div_go;

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign tag_out   = r_tag;
  assign illegal   = r_illegal;

  assign w_shamt = rhs[c_SHW-1:0];

  // One multiplier serves all MUL* forms: operands are sign- or zero-extended
  // to double width, so the low 2*W bits of the product are exact.
  assign w_a_ext = {{DATA_WIDTH{lhs[DATA_WIDTH-1] & ((funct3 == F3_MULH) || (funct3 == F3_MULHSU))}}, lhs};
  assign w_b_ext = {{DATA_WIDTH{rhs[DATA_WIDTH-1] & (funct3 == F3_MULH)}}, rhs};
  assign w_prod  = w_a_ext * w_b_ext;

  // DIV/REM are even funct3 codes, REM/REMU have bit 1 set.
  assign w_div_signed = ~funct3[0];
  assign w_div_rem    = funct3[1];
  assign w_lhs_neg    = w_div_signed && lhs[DATA_WIDTH-1];
  assign w_rhs_neg    = w_div_signed && rhs[DATA_WIDTH-1];
  assign w_lhs_mag    = w_lhs_neg ? (-lhs) : lhs;
  assign w_rhs_mag    = w_rhs_neg ? (-rhs) : rhs;
  assign w_div_by0    = (rhs == '0);
  assign w_div_ovf    = w_div_signed && (lhs == c_MIN) && (rhs == '1);

  // Decode and compute every single-cycle result; flag divides for the FSM.
  always_comb begin
    w_res     = '0;
    w_illegal = 1'b0;
    w_div_go  = 1'b0;
    case (funct7)
      F7_BASE: begin
        case (funct3)
          F3_ADD:  w_res = lhs + rhs;
          F3_SLL:  w_res = lhs << w_shamt;
          F3_SLT:  w_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(lhs) < $signed(rhs))};
          F3_SLTU: w_res = {{(DATA_WIDTH-1){1'b0}}, (lhs < rhs)};
          F3_XOR:  w_res = lhs ^ rhs;
          F3_SR:   w_res = lhs >> w_shamt;
          F3_OR:   w_res = lhs | rhs;
          default: w_res = lhs & rhs;
        endcase
      end
      F7_ALT: begin
        if (funct3 == F3_ADD)     w_res = lhs - rhs;
        else if (funct3 == F3_SR) w_res = $signed(lhs) >>> w_shamt;
        else                      w_illegal = 1'b1;
      end
      F7_MULDIV: begin
        if (MULDIV_EN != 0) begin
          case (funct3)
            F3_MUL:                       w_res = w_prod[DATA_WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_res = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            default: begin
              if (w_div_by0)      w_res = w_div_rem ? lhs : '1;
              else if (w_div_ovf) w_res = w_div_rem ? '0 : c_MIN;
              else                w_div_go = 1'b1;
            end
          endcase
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
  end

  div_iter #(.DATA_WIDTH(DATA_WIDTH)) u_div (
    .clk         (clk),
    .rst_n       (rst),
    .i_start     (w_div_start),
    .i_dividend  (w_lhs_mag),
    .i_divisor   (w_rhs_mag),
    .o_done      (w_div_done),
    .o_quotient  (w_q),
    .o_remainder (w_r)
  );

  // Sign fix-up: quotient negated when signs differ, remainder follows lhs.
  assign w_div_res = r_is_rem ? (r_neg_r ? -w_r : w_r)
                              : (r_neg_q ? -w_q : w_q);

  // Capture divide sign/selection context and tag at accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_is_rem  <= 1'b0;
      r_div_tag <= '0;
    end else if (w_div_start) begin
      r_neg_q   <= w_lhs_neg ^ w_rhs_neg;
      r_neg_r   <= w_lhs_neg;
      r_is_rem  <= w_div_rem;
      r_div_tag <= tag_in;
    end
  end

  // Control FSM: IDLE accepts, DIV waits on the divider, DONE holds until consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_div_start) r_state <= DIV;
        DIV:     if (w_div_done)  r_state <= DONE;
        DONE:    if (out_ready)   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output register: loads on divide completion or single-cycle accept, holds while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_tag       <= '0;
      r_illegal   <= 1'b0;
    end else if (w_div_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_div_res;
      r_tag       <= r_div_tag;
      r_illegal   <= 1'b0;
    end else if (w_accept && !w_div_go) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_tag       <= tag_in;
      r_illegal   <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_muldiv
//  Purpose  : Directed self-checking bench for alu_muldiv (32-bit), with a
//             second instance built without RV32M.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_muldiv;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  tag_out;
  logic        illegal;

  logic        u0_in_ready;
  logic        u0_out_valid;
  logic [31:0] u0_result;
  logic [4:0]  u0_tag_out;
  logic        u0_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  alu_muldiv #(.DATA_WIDTH(32), .TAG_WIDTH(5), .MULDIV_EN(1)) dut (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .lhs(lhs), .rhs(rhs), .funct3(funct3), .funct7(funct7), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .tag_out(tag_out), .illegal(illegal)
  );

  alu_muldiv #(.DATA_WIDTH(32), .TAG_WIDTH(5), .MULDIV_EN(0)) dut_nomd (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(u0_in_ready),
    .lhs(lhs), .rhs(rhs), .funct3(funct3), .funct7(funct7), .tag_in(tag_in),
    .out_valid(u0_out_valid), .out_ready(1'b1), .result(u0_result),
    .tag_out(u0_tag_out), .illegal(u0_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    in_valid = 1'b1; funct3 = f3; funct7 = f7; lhs = a; rhs = b; tag_in = t;
  endtask

  task automatic release_in();
    in_valid = 1'b0; lhs = 32'hDEAD_BEEF; rhs = 32'h0BAD_F00D; tag_in = 5'd31;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; funct3 = 3'd0; funct7 = 7'h00;
    release_in();
    #2;
    n_checks++;
    if ({out_valid, illegal, tag_out, result} !== '0)
      $display("FAIL reset_outputs: got valid=%b illegal=%b tag=%0d result=%h, want all zero",
               out_valid, illegal, tag_out, result);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_basic();
    logic [2:0]  f3 [3] = '{3'd0, 3'd5, 3'd7};
    logic [6:0]  f7 [3] = '{7'h00, 7'h20, 7'h00};
    logic [31:0] a  [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hF0F0_1234};
    logic [31:0] b  [3] = '{32'h0000_0001, 32'h0000_0021, 32'h0FF0_FF00};
    logic [31:0] ex [3] = '{32'h8000_0000, 32'hC000_0000, 32'h00F0_1200};
    for (int i = 0; i < 3; i++) begin
      drive(f3[i], f7[i], a[i], b[i], 5'(i + 3));
      @(negedge clk);
      release_in();
      n_checks++;
      if (out_valid !== 1'b1 || result !== ex[i] || tag_out !== 5'(i + 3) || illegal !== 1'b0)
        $display("FAIL alu_basic[%0d]: got valid=%b result=%h tag=%0d illegal=%b, want 1 %h %0d 0",
                 i, out_valid, result, tag_out, illegal, ex[i], i + 3);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3 [8] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [6:0]  f7 [8] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    logic [31:0] ex [8] = '{32'h8000_0101, 32'h8000_00DF, 32'h01E0_0000, 32'h0000_0001,
                            32'h0000_0000, 32'h8000_00E1, 32'h0000_4000, 32'h8000_00F1};
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || result !== ex[i-1] || tag_out !== 5'(i - 1) || illegal !== 1'b0)
          $display("FAIL b2b_result[%0d]: got valid=%b result=%h tag=%0d illegal=%b, want 1 %h %0d 0",
                   i - 1, out_valid, result, tag_out, illegal, ex[i-1], i - 1);
        else n_pass++;
      end
      if (i < 8) begin
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready);
        else n_pass++;
        drive(f3[i], f7[i], 32'h8000_00F0, 32'h0000_0011, 5'(i));
        @(negedge clk);
      end else begin
        release_in();
      end
    end
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  f3 [4] = '{3'd1, 3'd2, 3'd0, 3'd3};
    logic [31:0] a  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] b  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] ex [4] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFE};
    for (int i = 0; i < 4; i++) begin
      drive(f3[i], 7'h01, a[i], b[i], 5'(10 + i));
      @(negedge clk);
      release_in();
      n_checks++;
      if (out_valid !== 1'b1 || result !== ex[i] || tag_out !== 5'(10 + i) || illegal !== 1'b0)
        $display("FAIL mul[%0d]: got valid=%b result=%h tag=%0d illegal=%b, want 1 %h %0d 0",
                 i, out_valid, result, tag_out, illegal, ex[i], 10 + i);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  // Long divide: result at cycle 33, optional consumer stall afterwards.
  task automatic test_div_long(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                               input logic [4:0] t, input logic [31:0] ex, input int stall,
                               input string name);
    bit bad;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL %s_accept: in_ready got %b want 1", name, in_ready);
    else n_pass++;
    drive(f3, 7'h01, a, b, t);
    @(negedge clk);
    release_in();
    out_ready = (stall == 0);
    bad = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad) $display("FAIL %s_busy: in_ready/out_valid not 0 during cycles 1..32 (got 1, want 0)", name);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b1 || result !== ex || tag_out !== t || illegal !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL %s_result: got valid=%b result=%h tag=%0d illegal=%b rdy=%b, want 1 %h %0d 0 0",
               name, out_valid, result, tag_out, illegal, in_ready, ex, t);
    else n_pass++;
    if (stall > 0) begin
      bad = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || result !== ex || tag_out !== t || in_ready !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad) $display("FAIL %s_hold: output not held during stall (got change, want stable)", name);
      else n_pass++;
      out_ready = 1'b1;
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s_release: got valid=%b rdy=%b, want 0 1", name, out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_div_special();
    logic [2:0]  f3 [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] a  [4] = '{32'h1234_5678, 32'h0000_0005, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b  [4] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex [4] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      drive(f3[i], 7'h01, a[i], b[i], 5'(20 + i));
      @(negedge clk);
      release_in();
      n_checks++;
      if (out_valid !== 1'b1 || result !== ex[i] || tag_out !== 5'(20 + i) || in_ready !== 1'b1)
        $display("FAIL div_special[%0d]: got valid=%b result=%h tag=%0d rdy=%b, want 1 %h %0d 1",
                 i, out_valid, result, tag_out, in_ready, ex[i], 20 + i);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic [2:0] f3 [2] = '{3'd4, 3'd0};
    logic [6:0] f7 [2] = '{7'h20, 7'h05};
    for (int i = 0; i < 2; i++) begin
      drive(f3[i], f7[i], 32'h1234_5678, 32'h0000_0003, 5'(i + 1));
      @(negedge clk);
      release_in();
      n_checks++;
      if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0 || tag_out !== 5'(i + 1))
        $display("FAIL illegal[%0d]: got valid=%b illegal=%b result=%h tag=%0d, want 1 1 0 %0d",
                 i, out_valid, illegal, result, tag_out, i + 1);
      else n_pass++;
    end
    drive(3'd0, 7'h01, 32'd3, 32'd5, 5'd7);
    @(negedge clk);
    release_in();
    n_checks++;
    if (out_valid !== 1'b1 || illegal !== 1'b0 || result !== 32'd15)
      $display("FAIL mul_enabled: got valid=%b illegal=%b result=%h, want 1 0 0000000f",
               out_valid, illegal, result);
    else n_pass++;
    n_checks++;
    if (u0_out_valid !== 1'b1 || u0_illegal !== 1'b1 || u0_result !== 32'h0 || u0_tag_out !== 5'd7)
      $display("FAIL mul_disabled: got valid=%b illegal=%b result=%h tag=%0d, want 1 1 0 7",
               u0_out_valid, u0_illegal, u0_result, u0_tag_out);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_div();
    bit bad;
    drive(3'd5, 7'h01, 32'd100, 32'd7, 5'd4);
    @(negedge clk);
    release_in();
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_mid_div: got valid=%b rdy=%b, want 0 1", out_valid, in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL reset_abort: output appeared after reset release (got valid, want none)");
    else n_pass++;
    test_div_long(32'd100, 32'd7, 3'd5, 5'd4, 32'd14, 0, "divu_after_reset");
    test_div_long(32'd100, 32'd7, 3'd7, 5'd5, 32'd2, 2, "remu_after_reset");
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_alu_basic();
    test_back_to_back();
    test_mul();
    test_div_long(32'hFFFF_FFF9, 32'd2, 3'd4, 5'd9,  32'hFFFF_FFFD, 5, "div_neg");
    test_div_long(32'hFFFF_FFF9, 32'd2, 3'd6, 5'd10, 32'hFFFF_FFFF, 0, "rem_neg");
    test_div_special();
    test_illegal();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
